// File: rtl/pc_stack_n2t.sv
// Program counter with a LIFO return-address stack (load/inc/call/ret; priority reset > ret > call > load > inc).
// One-cycle latency from sampled controls to outputs, no backpressure; overflow/underflow are sticky until reset.
module pc_stack_n2t #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] out_inc;
    logic             is_empty;
    logic             is_full;

    assign out_inc  = out_q + WIDTH'(1);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);
    assign wr_idx   = AW'(count_q);
    assign rd_idx   = AW'(count_q - CW'(1));

    always_comb begin
        out_d       = out_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        if (reset) begin
            out_d       = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (ret) begin
            // A simultaneous call is dropped silently; ret alone decides the flags.
            if (is_empty) begin
                underflow_d = 1'b1;
            end else begin
                out_d   = mem_q[rd_idx];
                count_d = count_q - CW'(1);
            end
        end else if (call) begin
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + CW'(1);
                out_d   = in;
            end
        end else if (load) begin
            out_d = in;
        end else if (inc) begin
            out_d = out_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Return storage is never reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= out_inc;
        end
    end

    assign out       = out_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack_n2t.sv
module tb_pc_stack_n2t;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        load;
    logic        inc;
    logic        call;
    logic        ret;
    logic [15:0] dout;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int total;
    int bad;

    pc_stack_n2t #(.WIDTH(16), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .load      (load),
        .inc       (inc),
        .call      (call),
        .ret       (ret),
        .out       (dout),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic        in_c;
        logic        cl;
        logic        rt;
        logic [15:0] a;
        logic [15:0] exp_out;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_ovf;
        logic        exp_unf;
        string       name;
    } vec_t;

    localparam logic O = 1'b1;
    localparam logic Z = 1'b0;
    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic l, input logic i, input logic c,
                         input logic t, input logic [15:0] a);
        reset = r; load = l; inc = i; call = c; ret = t; din = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [15:0] eo, input logic ee,
                           input logic ef, input logic eov, input logic eun);
        chk({nm, ".out"}, dout, eo);
        chk({nm, ".empty"}, 16'(empty), 16'(ee));
        chk({nm, ".full"}, 16'(full), 16'(ef));
        chk({nm, ".overflow"}, 16'(overflow), 16'(eov));
        chk({nm, ".underflow"}, 16'(underflow), 16'(eun));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; din = 16'h0;

        //            rst ld inc cl rt  in        out       emp ful ovf unf
        vecs[0]  = '{O, O, O, O, O, 16'h1234, 16'h0000, O, Z, Z, Z, "reset_all_ctl"};
        vecs[1]  = '{Z, Z, O, Z, Z, 16'h0000, 16'h0001, O, Z, Z, Z, "inc1"};
        vecs[2]  = '{Z, Z, O, Z, Z, 16'h0000, 16'h0002, O, Z, Z, Z, "inc2"};
        vecs[3]  = '{Z, Z, O, Z, Z, 16'h0000, 16'h0003, O, Z, Z, Z, "inc3"};
        vecs[4]  = '{Z, O, Z, Z, Z, 16'h7FFF, 16'h7FFF, O, Z, Z, Z, "load_7fff"};
        vecs[5]  = '{Z, Z, O, Z, Z, 16'h0000, 16'h8000, O, Z, Z, Z, "inc_8000"};
        vecs[6]  = '{Z, O, Z, Z, Z, 16'hFFFF, 16'hFFFF, O, Z, Z, Z, "load_ffff"};
        vecs[7]  = '{Z, Z, O, Z, Z, 16'h0000, 16'h0000, O, Z, Z, Z, "inc_wrap"};
        vecs[8]  = '{Z, O, Z, Z, Z, 16'h0010, 16'h0010, O, Z, Z, Z, "load_0010"};
        vecs[9]  = '{Z, Z, Z, O, Z, 16'h0200, 16'h0200, Z, Z, Z, Z, "call_0200"};
        vecs[10] = '{Z, Z, Z, O, Z, 16'h0300, 16'h0300, Z, Z, Z, Z, "call_0300"};
        vecs[11] = '{Z, Z, Z, Z, O, 16'h0000, 16'h0201, Z, Z, Z, Z, "ret_0201"};
        vecs[12] = '{Z, Z, Z, Z, O, 16'h0000, 16'h0011, O, Z, Z, Z, "ret_0011"};
        vecs[13] = '{Z, Z, Z, Z, O, 16'h0000, 16'h0011, O, Z, Z, O, "ret_empty"};
        vecs[14] = '{Z, Z, O, Z, Z, 16'h0000, 16'h0012, O, Z, Z, O, "inc_after_unf"};
        vecs[15] = '{Z, O, O, Z, Z, 16'h0500, 16'h0500, O, Z, Z, O, "load_over_inc"};
        vecs[16] = '{O, Z, Z, Z, Z, 16'h0000, 16'h0000, O, Z, Z, Z, "reset_clears_unf"};
        vecs[17] = '{Z, O, Z, Z, Z, 16'h0041, 16'h0041, O, Z, Z, Z, "load_0041"};
        vecs[18] = '{Z, Z, Z, O, Z, 16'h0099, 16'h0099, Z, Z, Z, Z, "call_push_0042"};
        vecs[19] = '{Z, Z, Z, O, O, 16'h1111, 16'h0042, O, Z, Z, Z, "call_ret_same"};
        vecs[20] = '{Z, O, Z, O, Z, 16'h0123, 16'h0123, Z, Z, Z, Z, "call_over_load"};
        vecs[21] = '{O, Z, Z, O, O, 16'h5555, 16'h0000, O, Z, Z, Z, "reset_midstack"};
        vecs[22] = '{Z, Z, Z, Z, O, 16'h0000, 16'h0000, O, Z, Z, O, "ret_after_reset"};
        vecs[23] = '{O, Z, Z, Z, Z, 16'h0000, 16'h0000, O, Z, Z, Z, "reset_again"};

        for (int k = 0; k < NV; k++) begin
            apply(vecs[k].rst, vecs[k].ld, vecs[k].in_c, vecs[k].cl, vecs[k].rt, vecs[k].a);
            chk_all(vecs[k].name, vecs[k].exp_out, vecs[k].exp_empty, vecs[k].exp_full,
                    vecs[k].exp_ovf, vecs[k].exp_unf);
        end

        // Fill all 8 entries: pushes are 0x0001, then 0x1001..0x1007.
        for (int k = 0; k < 8; k++) begin
            apply(Z, Z, Z, O, Z, 16'h1000 + 16'(k));
            chk_all($sformatf("fill%0d", k), 16'h1000 + 16'(k), Z, (k == 7), Z, Z);
        end
        apply(Z, Z, Z, O, Z, 16'hABCD);
        chk_all("call_when_full", 16'h1007, Z, O, O, Z);

        for (int k = 0; k < 8; k++) begin
            logic [15:0] e;
            e = (k == 7) ? 16'h0001 : 16'h1000 + 16'(7 - k);
            apply(Z, Z, Z, Z, O, 16'h0000);
            chk_all($sformatf("drain%0d", k), e, (k == 7), Z, O, Z);
        end

        // Overflow stays set but does not block later calls.
        apply(Z, Z, Z, O, Z, 16'h0777);
        chk_all("call_after_ovf", 16'h0777, Z, Z, O, Z);
        apply(Z, Z, Z, Z, O, 16'h0000);
        chk_all("ret_after_ovf", 16'h0002, O, Z, O, Z);
        apply(O, Z, Z, Z, Z, 16'h0000);
        chk_all("final_reset", 16'h0000, O, Z, Z, Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
